// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end.
// Owns the fetch address, issues single-cycle-latency reads to a synchronous
// instruction memory, buffers returned words with their addresses in a small
// FIFO, and hands them to decode over a valid/ready handshake. A redirect
// flushes everything buffered or in flight and restarts fetch at a new address.
module fetch_queue #(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter int                DEPTH      = 4,
    parameter int                ADDR_INC   = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_addr,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr_data,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] INC_C   = ADDR_W'(ADDR_INC);

    logic [ADDR_W-1:0]  fetch_pc_p0;
    logic               vld_p1;
    logic [ADDR_W-1:0]  pc_p1;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic               kill;
    logic               push;
    logic               pop;

    // A response returning while a redirect is active belongs to the old
    // stream; kill drops it so it never reaches the FIFO.
    assign kill = redirect;
    assign push = vld_p1 & ~kill;
    // The flush wins over a simultaneous pop.
    assign pop  = instr_valid & instr_ready & ~redirect;

    // Credit counts buffered entries plus the one possibly in flight; a pop
    // this cycle only frees a slot next cycle, so overflow cannot happen.
    assign imem_req  = rst_n & fetch_en & ~redirect &
                       (({1'b0, count} + (CNT_W + 1)'(vld_p1)) < DEPTH_C);
    assign imem_addr = fetch_pc_p0;

    assign instr_valid = (count != '0);
    assign instr_data  = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;
    assign fifo_count  = count;

    // Fetch address, in-flight flag and FIFO bookkeeping; redirect flushes all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_p0 <= RESET_ADDR;
            vld_p1      <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect) begin
            fetch_pc_p0 <= redirect_addr;
            vld_p1      <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (imem_req)
                fetch_pc_p0 <= fetch_pc_p0 + INC_C;
            vld_p1 <= imem_req;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- stage p1: request address follows the memory read by one cycle ----
    // Datapath storage carries no reset; validity is tracked by count/vld_p1.
    always_ff @(posedge clk) begin
        pc_p1 <= imem_addr;
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= pc_p1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                    count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scenario tasks plus a randomized run against a queue-based
// model of the fetch front end (FIFO of addresses, one pending response).
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'h0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: buffered addresses, pending response, next fetch.
    logic [15:0] m_fifo[$];
    bit          m_infl;
    logic [15:0] m_inpc;
    logic [15:0] m_pc;

    fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .ADDR_INC(1), .RESET_ADDR(16'h0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_addr(redirect_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word at address a holds a ^ 0xA000, one cycle later.
    always @(posedge clk) imem_rdata <= imem_addr ^ 16'hA000;

    function automatic bit m_req();
        return rst_n && fetch_en && !redirect && ((m_fifo.size() + (m_infl ? 1 : 0)) < DEPTH);
    endfunction

    // Advance the model across one rising edge, then wait for it (+1).
    task automatic tick();
        bit req;
        bit pop;
        req = m_req();
        pop = (m_fifo.size() != 0) && instr_ready && !redirect;
        if (!rst_n) begin
            m_fifo.delete(); m_infl = 0; m_pc = 16'h0;
        end else if (redirect) begin
            m_fifo.delete(); m_infl = 0; m_pc = redirect_addr;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_infl) m_fifo.push_back(m_inpc);
            m_infl = req;
            m_inpc = m_pc;
            if (req) m_pc = m_pc + 16'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
        m_fifo.delete(); m_infl = 0; m_pc = 16'h0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else n_pass++;
        n_checks++; if (instr_pc !== 16'h0) $display("FAIL reset_pc: got %h expected 0000", instr_pc); else n_pass++;
        n_checks++; if (instr_data !== 16'h0) $display("FAIL reset_data: got %h expected 0000", instr_data); else n_pass++;
    endtask

    task automatic test_stream();
        int          first_valid;
        logic [15:0] exp;
        first_valid = -1; exp = 16'h0;
        do_reset();
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #4;
            if (c == 0) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) $display("FAIL stream_first_req: got req=%b addr=%h expected 1/0000", imem_req, imem_addr); else n_pass++;
            end
            if (instr_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (c >= 2) begin
                n_checks++; if (instr_valid !== 1'b1 || instr_pc !== exp || instr_data !== (exp ^ 16'hA000)) $display("FAIL stream_cycle%0d: got v=%b pc=%h d=%h expected 1/%h/%h", c, instr_valid, instr_pc, instr_data, exp, exp ^ 16'hA000); else n_pass++;
                exp = exp + 16'd1;
            end
            tick();
        end
        n_checks++; if (first_valid != 2) $display("FAIL stream_latency: got first valid cycle %0d expected 2", first_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        int          nreq;
        logic [15:0] exp;
        nreq = 0; exp = 16'h0;
        do_reset();
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (imem_req === 1'b1) begin
                n_checks++; if (imem_addr !== 16'(nreq)) $display("FAIL bp_addr: got %h expected %h", imem_addr, 16'(nreq)); else n_pass++;
                nreq++;
            end
            tick();
        end
        instr_ready = 1'b1;
        #4;
        n_checks++; if (nreq != 4) $display("FAIL bp_nreq: got %0d expected 4", nreq); else n_pass++;
        n_checks++; if (fifo_count !== 3'd4) $display("FAIL bp_count: got %0d expected 4", fifo_count); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL bp_full_req: got %b expected 0", imem_req); else n_pass++;
        for (int c = 0; c < 24; c++) begin
            if (instr_valid === 1'b1) begin
                n_checks++; if (instr_pc !== exp || instr_data !== (exp ^ 16'hA000)) $display("FAIL bp_drain: got pc=%h d=%h expected %h/%h", instr_pc, instr_data, exp, exp ^ 16'hA000); else n_pass++;
                exp = exp + 16'd1;
            end
            tick(); #4;
        end
        n_checks++; if (exp < 16'd8) $display("FAIL bp_drain_progress: got %0d delivered expected >=8", exp); else n_pass++;
    endtask

    task automatic test_redirect_flush();
        logic [15:0] exp;
        int          got;
        exp = 16'h0040; got = 0;
        do_reset();
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #4; tick();
        end
        #4;
        n_checks++; if (fifo_count !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", fifo_count); else n_pass++;
        redirect = 1'b1; redirect_addr = 16'h0040;
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL flush_req_in_redirect: got %b expected 0", imem_req); else n_pass++;
        tick();
        redirect = 1'b0; instr_ready = 1'b1;
        #4;
        n_checks++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL flush_empty: got v=%b cnt=%0d expected 0/0", instr_valid, fifo_count); else n_pass++;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) $display("FAIL flush_restart: got req=%b addr=%h expected 1/0040", imem_req, imem_addr); else n_pass++;
        for (int c = 0; c < 12; c++) begin
            if (instr_valid === 1'b1) begin
                n_checks++; if (instr_pc !== exp) $display("FAIL flush_seq: got pc=%h expected %h", instr_pc, exp); else n_pass++;
                exp = exp + 16'd1; got++;
            end
            tick(); #4;
        end
        n_checks++; if (got == 0) $display("FAIL flush_no_output: got 0 delivered expected >0"); else n_pass++;
    endtask

    task automatic test_redirect_pop();
        logic [15:0] addr;
        bit          seen;
        addr = 16'($urandom); seen = 0;
        do_reset();
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #4; tick();
        end
        redirect = 1'b1; redirect_addr = addr;
        #4;
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL rpop_valid_before: got %b expected 1", instr_valid); else n_pass++;
        tick();
        redirect = 1'b0;
        #4;
        n_checks++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL rpop_empty: got v=%b cnt=%0d expected 0/0", instr_valid, fifo_count); else n_pass++;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (instr_valid === 1'b1) begin
                seen = 1;
                n_checks++; if (instr_pc !== addr) $display("FAIL rpop_first_pc: got %h expected %h", instr_pc, addr); else n_pass++;
            end
            tick(); #4;
        end
        n_checks++; if (!seen) $display("FAIL rpop_timeout: got no output expected pc %h", addr); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [15:0] exp_tab [4];
        int          got;
        exp_tab[0] = 16'hFFFE; exp_tab[1] = 16'hFFFF; exp_tab[2] = 16'h0000; exp_tab[3] = 16'h0001;
        got = 0;
        do_reset();
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        redirect = 1'b1; redirect_addr = 16'hFFFE;
        tick();
        redirect = 1'b0;
        #4;
        for (int c = 0; c < 15 && got < 4; c++) begin
            if (instr_valid === 1'b1) begin
                n_checks++; if (instr_pc !== exp_tab[got]) $display("FAIL wrap_pc%0d: got %h expected %h", got, instr_pc, exp_tab[got]); else n_pass++;
                got++;
            end
            tick(); #4;
        end
        n_checks++; if (got != 4) $display("FAIL wrap_timeout: got %0d outputs expected 4", got); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        int          got;
        exp = 16'h0; got = 0;
        do_reset();
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #4; tick();
        end
        #4;
        n_checks++; if (fifo_count !== 3'd2) $display("FAIL rmid_pre_count: got %0d expected 2", fifo_count); else n_pass++;
        rst_n = 1'b0;
        m_fifo.delete(); m_infl = 0; m_pc = 16'h0;
        #1;
        n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || fifo_count !== 3'd0) $display("FAIL rmid_async: got v=%b req=%b cnt=%0d expected 0/0/0", instr_valid, imem_req, fifo_count); else n_pass++;
        tick();
        rst_n = 1'b1; instr_ready = 1'b1;
        #4;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) $display("FAIL rmid_restart: got req=%b addr=%h expected 1/0000", imem_req, imem_addr); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            if (instr_valid === 1'b1) begin
                n_checks++; if (instr_pc !== exp) $display("FAIL rmid_seq: got pc=%h expected %h", instr_pc, exp); else n_pass++;
                exp = exp + 16'd1; got++;
            end
            tick(); #4;
        end
        n_checks++; if (got == 0) $display("FAIL rmid_no_output: got 0 delivered expected >0"); else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            fetch_en      = ($urandom_range(0, 3) != 0);
            instr_ready   = ($urandom_range(0, 2) != 0);
            redirect      = ($urandom_range(0, 24) == 0);
            redirect_addr = 16'($urandom);
            #4;
            n_checks++; if (imem_req !== m_req()) $display("FAIL rand_req c%0d: got %b expected %b", c, imem_req, m_req()); else n_pass++;
            if (m_req()) begin
                n_checks++; if (imem_addr !== m_pc) $display("FAIL rand_addr c%0d: got %h expected %h", c, imem_addr, m_pc); else n_pass++;
            end
            n_checks++; if (fifo_count !== 3'(m_fifo.size())) $display("FAIL rand_count c%0d: got %0d expected %0d", c, fifo_count, m_fifo.size()); else n_pass++;
            n_checks++; if (instr_valid !== (m_fifo.size() != 0)) $display("FAIL rand_valid c%0d: got %b expected %b", c, instr_valid, m_fifo.size() != 0); else n_pass++;
            if (m_fifo.size() != 0) begin
                n_checks++; if (instr_pc !== m_fifo[0] || instr_data !== (m_fifo[0] ^ 16'hA000)) $display("FAIL rand_head c%0d: got pc=%h d=%h expected %h/%h", c, instr_pc, instr_data, m_fifo[0], m_fifo[0] ^ 16'hA000); else n_pass++;
            end
            tick();
        end
        redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
